alu_cmd_issuer: RTL and testbench

Initiator-side companion to the team's 8-bit ALU. It accepts ALU commands (opcode plus two operands) on a valid/ready interface and buffers them in a small FIFO. Each command is issued to the ALU as a one-cycle enable pulse, and the block waits for the ALU's registered result and ready. The captured result and status are returned on a valid/ready response interface with backpressure. It sits between a bus/host front-end and the ALU instance, and it owns the ALU's alu_enable/alu_in1/alu_in2/alu_op inputs.

---
 rtl/alu_cmd_issuer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, issues each as a one-cycle enable
// pulse, and returns the ALU result (or a timeout) on a valid/ready response port.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [7:0]       cmd_in1,
  input  logic [7:0]       cmd_in2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [4:0]       rsp_status,
  output logic             rsp_timeout,
  output logic             alu_enable,
  output logic [7:0]       alu_in1,
  output logic [7:0]       alu_in2,
  output logic [4:0]       alu_op,
  input  logic [7:0]       alu_out,
  input  logic [4:0]       alu_status,
  input  logic             alu_ready,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [20:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             rsp_valid_q, rsp_valid_d, timeout_q, timeout_d, enable_q;
  logic [7:0]       result_q, result_d, in1_q, in2_q;
  logic [4:0]       status_q, status_d, op_q;
  logic             push, pop;

  assign cmd_ready = count_q != CNT_W'(FIFO_DEPTH);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state_q == IDLE && count_q != '0;
  assign busy      = state_q != IDLE || count_q != '0;

  assign fifo_count  = count_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_status  = status_q;
  assign rsp_timeout = timeout_q;
  assign alu_enable  = enable_q;
  assign alu_op      = op_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;

  // Storage needs no reset; flushing is done by resetting the pointers and count.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_in1, cmd_in2};

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    status_d    = status_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE:  if (pop) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: if (alu_ready) begin
        result_d    = alu_out;
        status_d    = alu_status;
        timeout_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end else begin
        wcnt_d = wcnt_q + TW'(1);
        if (wcnt_d == TW'(TIMEOUT_CYCLES)) begin
          result_d    = '0;
          status_d    = '0;
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      timeout_q   <= 1'b0;
      enable_q    <= 1'b0;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
      timeout_q   <= timeout_d;
      // Enable is high exactly for the ISSUE cycle that follows a pop.
      enable_q    <= pop;
      if (pop) {op_q, in1_q, in2_q} <= mem_q[rd_ptr_q];
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed test of alu_cmd_issuer against a simple registered ALU model.
module tb_alu_cmd_issuer;
  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_CMPEQ = 5'h08,
                         OP_CMPLT = 5'h09, OP_CMPGT = 5'h0A, OP_BAD = 5'h1F;
  logic       clk = 0, reset_n = 0, cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
  logic [4:0] cmd_op = 0, rsp_status, alu_op, alu_status;
  logic [7:0] cmd_in1 = 0, cmd_in2 = 0, rsp_result, alu_in1, alu_in2, alu_out;
  logic       rsp_timeout, alu_enable, alu_ready, busy, m_ready = 0, stall = 0;
  logic [2:0] fifo_count;
  logic [13:0] exp_q[$];
  int errors = 0, checks = 0, en_pulses = 0, rsp_seen = 0;

  alu_cmd_issuer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_status(rsp_status),
    .rsp_timeout(rsp_timeout), .alu_enable(alu_enable), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out), .alu_status(alu_status),
    .alu_ready(alu_ready), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] alu_fn(input logic [4:0] op, input logic [7:0] a, b);
    logic [8:0] s;
    case (op)
      OP_ADD:   begin s = {1'b0, a} + {1'b0, b}; return {s[8], s[7], 3'b0, s[7:0]}; end
      OP_SUB:   begin s = {1'b0, a} - {1'b0, b}; return {a >= b, s[7], 3'b0, s[7:0]}; end
      OP_CMPEQ: return {2'b0, a == b, 2'b0, 8'h00};
      OP_CMPLT: return {3'b0, a < b, 1'b0, 8'h00};
      OP_CMPGT: return {4'b0, a > b, 8'h00};
      default:  return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_ready <= alu_enable;
    if (alu_enable) {alu_status, alu_out} <= alu_fn(alu_op, alu_in1, alu_in2);
  end
  assign alu_ready = m_ready && !stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (alu_enable) en_pulses++;
    if (reset_n && rsp_valid) rsp_seen++;
    if (reset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
      else chk("rsp", {rsp_timeout, rsp_status, rsp_result}, exp_q.pop_front());
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [4:0] op, input logic [7:0] a, b, input logic [13:0] e);
    bit ok = 0;
    logic r;
    cmd_valid = 1; cmd_op = op; cmd_in1 = a; cmd_in2 = b;
    for (int i = 0; i < 200 && !ok; i++) begin r = cmd_ready; step(); ok = r; end
    cmd_valid = 0;
    if (ok) exp_q.push_back(e); else chk("push_accept", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin step(); n++; end
    if (!rsp_valid) chk("rsp_wait", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) step();
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    int n, base;
    logic ok;
    step(2);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_status, rsp_result}, 0);
    chk("rst_alu", {alu_enable, alu_op, alu_in1, alu_in2}, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy_rdy", {busy, cmd_ready}, 2'b01);
    reset_n = 1;
    step();
    // single ADD latency and pulse shape
    rsp_ready = 1;
    base = en_pulses;
    push(OP_ADD, 8'hF0, 8'h20, {1'b0, 5'b10000, 8'h10});
    chk("lat_p0_en", alu_enable, 0);
    step();
    chk("lat_p1_en", alu_enable, 1);
    chk("lat_p1_ops", {alu_op, alu_in1, alu_in2}, {OP_ADD, 8'hF0, 8'h20});
    chk("lat_p1_busy", busy, 1);
    step();
    chk("lat_p2", {alu_enable, rsp_valid}, 0);
    step();
    chk("lat_p3_valid", rsp_valid, 1);
    chk("lat_p3_rsp", {rsp_timeout, rsp_status, rsp_result}, {1'b0, 5'b10000, 8'h10});
    drain();
    chk("add_one_pulse", en_pulses - base, 1);
    chk("operand_hold", {alu_op, alu_in1, alu_in2}, {OP_ADD, 8'hF0, 8'h20});
    // compares and an unsupported opcode
    push(OP_CMPLT, 8'd5, 8'd9, {1'b0, 5'b00010, 8'h00});
    push(OP_CMPEQ, 8'd7, 8'd7, {1'b0, 5'b00100, 8'h00});
    push(OP_CMPGT, 8'd2, 8'd1, {1'b0, 5'b00001, 8'h00});
    push(OP_BAD, 8'h55, 8'h66, 14'h0);
    drain();
    // backpressure: response must hold, nothing new issues
    rsp_ready = 0;
    push(OP_SUB, 8'h03, 8'h05, {1'b0, 5'b01000, 8'hFE});
    push(OP_ADD, 8'h01, 8'h02, {1'b0, 5'b00000, 8'h03});
    wait_valid(n);
    base = en_pulses;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!rsp_valid || rsp_result !== 8'hFE || rsp_status !== 5'b01000) ok = 0;
    end
    chk("bp_stable", ok, 1);
    chk("bp_no_issue", en_pulses - base, 0);
    chk("bp_count", fifo_count, 1);
    rsp_ready = 1;
    step();
    chk("bp_handshake", {rsp_valid, alu_enable}, 0);
    step();
    chk("bp_next_issue", alu_enable, 1);
    drain();
    // FIFO fill while the first response is blocked
    rsp_ready = 0;
    push(OP_ADD, 8'h01, 8'h01, {1'b0, 5'b00000, 8'h02});
    push(OP_ADD, 8'h02, 8'h03, {1'b0, 5'b00000, 8'h05});
    push(OP_ADD, 8'h10, 8'h20, {1'b0, 5'b00000, 8'h30});
    push(OP_ADD, 8'h80, 8'h80, {1'b0, 5'b10000, 8'h00});
    push(OP_ADD, 8'h7F, 8'h01, {1'b0, 5'b01000, 8'h80});
    chk("fill_count", fifo_count, 4);
    chk("fill_ready", cmd_ready, 0);
    cmd_valid = 1; cmd_op = OP_ADD; cmd_in1 = 8'hAA; cmd_in2 = 8'hBB;
    step(3);
    cmd_valid = 0;
    chk("fill_ignored", fifo_count, 4);
    rsp_ready = 1;
    push(OP_ADD, 8'h0A, 8'h05, {1'b0, 5'b00000, 8'h0F});
    drain();
    // timeout with alu_ready held low
    stall = 1;
    rsp_ready = 0;
    push(OP_ADD, 8'h11, 8'h22, {1'b1, 5'b00000, 8'h00});
    wait_valid(n);
    chk("to_cycles", n, 18);
    chk("to_rsp", {rsp_timeout, rsp_status, rsp_result}, {1'b1, 5'b00000, 8'h00});
    stall = 0;
    rsp_ready = 1;
    push(OP_ADD, 8'h01, 8'h02, {1'b0, 5'b00000, 8'h03});
    drain();
    // asynchronous reset mid-WAIT with two commands queued
    stall = 1;
    rsp_ready = 0;
    push(OP_ADD, 8'h01, 8'h01, 14'h0);
    push(OP_ADD, 8'h02, 8'h02, 14'h0);
    push(OP_ADD, 8'h03, 8'h03, 14'h0);
    step(3);
    chk("pre_rst_count", fifo_count, 2);
    #2 reset_n = 0;
    #1;
    chk("arst_count_busy", {fifo_count, busy}, 0);
    chk("arst_rsp", {rsp_valid, rsp_timeout, rsp_status, rsp_result}, 0);
    chk("arst_alu", {alu_enable, alu_op, alu_in1, alu_in2}, 0);
    exp_q.delete();
    step(2);
    reset_n = 1;
    stall = 0;
    rsp_ready = 1;
    base = en_pulses;
    n = rsp_seen;
    step(30);
    chk("post_rst_no_rsp", rsp_seen - n, 0);
    chk("post_rst_no_issue", en_pulses - base, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
